// File: rtl/imem_loader_if.sv
// imem_loader_if: groups the serial program-byte stream and the instruction-memory
// write port of imem_loader.
//   s_data/s_valid/s_ready  : byte stream from the program source into the loader
//   im_we/im_addr/im_wdata  : single-cycle word write into instruction memory
// Modports:
//   slave  : the loader (consumes the stream, drives the memory write port)
//   master : the environment (drives the stream, observes the memory write port)
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  modport slave (
    input  s_data, s_valid,
    output s_ready, im_we, im_addr, im_wdata
  );

  modport master (
    output s_data, s_valid,
    input  s_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: loads a program from a byte stream into instruction memory while
// holding the CPU in reset. Bytes are packed big-endian into 32-bit words, each word
// is written with a one-cycle im_we strobe, and done pulses when the load ends.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start, len  : load request (IDLE only) and word count, captured on start
//   bus         : imem_loader_if.slave (byte stream in, memory write port out)
//   cpu_hold    : 1 until a load has completed, and again while loading
//   done        : one-cycle completion pulse
//   err         : sticky checksum mismatch flag
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to expect a trailing XOR
// checksum byte after the program; without it err is tied to 0.
module imem_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  imem_loader_if.slave      bus,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int unsigned LEN_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              s_ready_q, s_ready_d;
  logic              im_we_q, im_we_d;
  logic              done_q, done_d;
  logic              cpu_hold_q, cpu_hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
  logic              err_q, err_d;
`endif

  logic accept;
  logic last_word;

  assign accept    = bus.s_valid & s_ready_q;
  // Compare in LEN_W bits so len = 2^ADDR_W ends at the all-ones address.
  assign last_word = ({1'b0, addr_q} == (len_q - LEN_W'(1)));

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      bcnt_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      s_ready_q  <= 1'b0;
      im_we_q    <= 1'b0;
      done_q     <= 1'b0;
      cpu_hold_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      bcnt_q     <= bcnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      s_ready_q  <= s_ready_d;
      im_we_q    <= im_we_d;
      done_q     <= done_d;
      cpu_hold_q <= cpu_hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
      err_q      <= err_d;
`endif
    end
  end

  // Next state; output values are computed for the state being entered
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    bcnt_d     = bcnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    s_ready_d  = s_ready_q;
    im_we_d    = 1'b0;
    done_d     = 1'b0;
    cpu_hold_d = cpu_hold_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
    err_d      = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d      = len;
          addr_d     = '0;
          bcnt_d     = '0;
          cpu_hold_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = '0;
          err_d      = 1'b0;
`endif
          if (len == '0) begin
            state_d   = DONE;
            done_d    = 1'b1;
            s_ready_d = 1'b0;
          end else begin
            state_d   = LOAD;
            s_ready_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          wdata_d = {wdata_q[23:0], bus.s_data};
          bcnt_d  = bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ bus.s_data;
`endif
          if (bcnt_q == 2'd3) begin
            state_d   = WRITE;
            s_ready_d = 1'b0;
            im_we_d   = 1'b1;
          end
        end
      end
      WRITE: begin
        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d   = CHECK;
          s_ready_d = 1'b1;
`else
          state_d   = DONE;
          done_d    = 1'b1;
`endif
        end else begin
          addr_d    = addr_q + ADDR_W'(1);
          state_d   = LOAD;
          s_ready_d = 1'b1;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept) begin
          if (bus.s_data != csum_q) begin
            err_d = 1'b1;
          end
          state_d   = DONE;
          done_d    = 1'b1;
          s_ready_d = 1'b0;
        end
      end
`endif
      DONE: begin
        state_d    = IDLE;
        cpu_hold_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.s_ready  = s_ready_q;
  assign bus.im_we    = im_we_q;
  assign bus.im_addr  = addr_q;
  assign bus.im_wdata = wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign err          = err_q;
`else
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader. Expected memory writes are queued
// when program bytes are driven and compared as the DUT strobes im_we.
module tb_imem_loader;

  localparam int unsigned AW = 8;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  typedef logic [7:0] byte_q_t [$];

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   len = '0;
  logic          cpu_hold;
  logic          done;
  logic          err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int acc_cnt = 0;
  int s0 = 0;
  wr_t exp_q [$];
  wr_t mon_e;

  imem_loader_if #(.ADDR_W(AW)) bus ();

  imem_loader #(.ADDR_W(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard side: pop and compare each memory write as it appears
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.im_we === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL im_write unexpected: got a=%0h d=%h, none expected", bus.im_addr, bus.im_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          if ({bus.im_addr, bus.im_wdata} !== mon_e) begin
            failures++;
            $display("FAIL im_write: got a=%0h d=%h, expected a=%0h d=%h",
                     bus.im_addr, bus.im_wdata, mon_e.a, mon_e.d);
          end
        end
      end
      if (done === 1'b1) done_cnt++;
      if (bus.s_valid === 1'b1 && bus.s_ready === 1'b1) acc_cnt++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic void push_words(input byte_q_t b, input int n);
    for (int w = 0; w < n; w++) begin
      exp_q.push_back(wr_t'{a: AW'(w), d: {b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]}});
    end
  endfunction

  function automatic logic [7:0] xsum(input byte_q_t b, input int n);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < n; i++) x = x ^ b[i];
    return x;
  endfunction

  task automatic start_load(input int l);
    len = (AW+1)'(l);
    start = 1'b1;
    @(posedge clk);
    #1;
    s0 = cyc;
    start = 1'b0;
  endtask

  // Drive bytes with s_valid held high; optional 3-cycle gap and stray start pulse
  task automatic send_bytes(input byte_q_t b, input int gap_at, input int start_at);
    int t;
    for (int i = 0; i < b.size(); i++) begin
      if (i == gap_at) begin
        bus.s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
      end
      if (i == start_at) begin
        start = 1'b1;
        len = (AW+1)'(5);
      end
      bus.s_data = b[i];
      bus.s_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (bus.s_ready !== 1'b1 && t < 40) begin
        @(negedge clk);
        t++;
      end
      checks++;
      if (bus.s_ready !== 1'b1) begin
        failures++;
        $display("FAIL s_ready_timeout: byte %0d not accepted, s_ready=%b expected 1", i, bus.s_ready);
        bus.s_valid = 1'b0;
        start = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok, output int at);
    ok = 1'b0;
    at = -1;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL rst_cpu_hold: got %b expected 1", cpu_hold); end
    checks++; if (bus.im_we !== 1'b0) begin failures++; $display("FAIL rst_im_we: got %b expected 0", bus.im_we); end
    checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL rst_s_ready: got %b expected 0", bus.s_ready); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b expected 0", done); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err: got %b expected 0", err); end
    checks++; if ({bus.im_addr, bus.im_wdata} !== 40'h0) begin failures++; $display("FAIL rst_bus: got a=%0h d=%h expected 0", bus.im_addr, bus.im_wdata); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    byte_q_t b = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h3C, 8'h09, 8'hFF, 8'hFF};
    int a0, d0, at;
    bit ok;
    if (CSUM != 0) b.push_back(xsum(b, 8));
    push_words(b, 2);
    a0 = acc_cnt;
    d0 = done_cnt;
    start_load(2);
    checks++; if (cpu_hold !== 1'b1 || bus.s_ready !== 1'b1) begin failures++; $display("FAIL basic_load_entry: cpu_hold=%b s_ready=%b expected 1 1", cpu_hold, bus.s_ready); end
    send_bytes(b, -1, -1);
    wait_done(50, ok, at);
    checks++; if (!ok) begin failures++; $display("FAIL basic_done_timeout: done not seen, expected pulse"); end
    checks++; if (at - s0 !== 10 + CSUM) begin failures++; $display("FAIL basic_done_cycle: got offset %0d expected %0d", at - s0, 10 + CSUM); end
    @(posedge clk);
    #1;
    checks++; if (cpu_hold !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL basic_after: cpu_hold=%b done=%b expected 0 0", cpu_hold, done); end
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt - d0); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL basic_writes_missing: %0d outstanding expected 0", exp_q.size()); end
    checks++; if (acc_cnt - a0 !== b.size()) begin failures++; $display("FAIL basic_bytes: got %0d expected %0d", acc_cnt - a0, b.size()); end
  endtask

  task automatic test_gap();
    byte_q_t b = '{8'h12, 8'h34, 8'h56, 8'h78};
    int a0, at;
    bit ok;
    if (CSUM != 0) b.push_back(xsum(b, 4));
    push_words(b, 1);
    a0 = acc_cnt;
    start_load(1);
    send_bytes(b, 2, -1);
    bus.s_data = 8'hAA;
    bus.s_valid = 1'b1;
    wait_done(50, ok, at);
    repeat (4) @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    checks++; if (!ok) begin failures++; $display("FAIL gap_done_timeout: done not seen, expected pulse"); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL gap_writes_missing: %0d outstanding expected 0", exp_q.size()); end
    checks++; if (acc_cnt - a0 !== b.size()) begin failures++; $display("FAIL gap_bytes: got %0d expected %0d", acc_cnt - a0, b.size()); end
  endtask

  task automatic test_checksum();
    byte_q_t b;
    int at;
    bit ok;
    logic [7:0] ck [2] = '{8'h0F, 8'h0E};
    for (int r = 0; r < 2; r++) begin
      b = '{8'h01, 8'h02, 8'h04, 8'h08};
      if (CSUM != 0) b.push_back(ck[r]);
      push_words(b, 1);
      start_load(1);
      send_bytes(b, -1, -1);
      wait_done(50, ok, at);
      checks++; if (!ok) begin failures++; $display("FAIL csum_done_%0d: done not seen, expected pulse", r); end
      checks++; if (err !== ((CSUM != 0) && r == 1)) begin failures++; $display("FAIL csum_err_%0d: got %b expected %b", r, err, (CSUM != 0) && r == 1); end
      repeat (3) @(posedge clk);
      #1;
      checks++; if (err !== ((CSUM != 0) && r == 1)) begin failures++; $display("FAIL csum_err_hold_%0d: got %b expected %b", r, err, (CSUM != 0) && r == 1); end
    end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL csum_writes_missing: %0d outstanding expected 0", exp_q.size()); end
  endtask

  task automatic test_start_ignored();
    byte_q_t b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    int a0, d0, at;
    bit ok;
    if (CSUM != 0) b.push_back(xsum(b, 8));
    push_words(b, 2);
    a0 = acc_cnt;
    d0 = done_cnt;
    start_load(2);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL start_clears_err: got %b expected 0", err); end
    send_bytes(b, -1, 3);
    wait_done(50, ok, at);
    checks++; if (!ok || at - s0 !== 10 + CSUM) begin failures++; $display("FAIL ign_done: ok=%b offset %0d expected offset %0d", ok, at - s0, 10 + CSUM); end
    @(posedge clk);
    #1;
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL ign_done_count: got %0d expected 1", done_cnt - d0); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL ign_writes_missing: %0d outstanding expected 0", exp_q.size()); end
    checks++; if (acc_cnt - a0 !== b.size()) begin failures++; $display("FAIL ign_bytes: got %0d expected %0d", acc_cnt - a0, b.size()); end
  endtask

  task automatic test_reset_mid();
    byte_q_t b = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    int d0;
    push_words(b, 1);
    d0 = done_cnt;
    start_load(4);
    send_bytes(b, -1, -1);
    rst_n = 1'b0;
    #1;
    checks++; if (cpu_hold !== 1'b1 || bus.s_ready !== 1'b0 || bus.im_we !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_async: cpu_hold=%b s_ready=%b im_we=%b done=%b expected 1 0 0 0", cpu_hold, bus.s_ready, bus.im_we, done);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (done_cnt !== d0) begin failures++; $display("FAIL mid_rst_no_done: got %0d pulses expected 0", done_cnt - d0); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL mid_rst_writes: %0d outstanding expected 0", exp_q.size()); end
    checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL mid_rst_hold: got %b expected 1", cpu_hold); end
    start_load(0);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL len0_done: got %b expected 1", done); end
    @(posedge clk);
    #1;
    checks++; if (cpu_hold !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL len0_after: cpu_hold=%b done=%b expected 0 0", cpu_hold, done); end
  endtask

  task automatic test_full_depth();
    byte_q_t b;
    int at;
    bit ok;
    for (int i = 0; i < 4 * (1 << AW); i++) b.push_back(8'(i * 7 + 3));
    if (CSUM != 0) b.push_back(xsum(b, 4 * (1 << AW)));
    push_words(b, 1 << AW);
    start_load(1 << AW);
    send_bytes(b, -1, -1);
    wait_done(50, ok, at);
    checks++; if (!ok) begin failures++; $display("FAIL full_done: done not seen, expected pulse"); end
    checks++; if (bus.im_addr !== AW'((1 << AW) - 1)) begin failures++; $display("FAIL full_last_addr: got %0h expected %0h", bus.im_addr, (1 << AW) - 1); end
    @(posedge clk);
    #1;
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL full_writes_missing: %0d outstanding expected 0", exp_q.size()); end
    checks++; if (cpu_hold !== 1'b0) begin failures++; $display("FAIL full_hold: got %b expected 0", cpu_hold); end
  endtask

  initial begin
    bus.s_data = 8'h00;
    bus.s_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_gap();
    test_checksum();
    test_start_ignored();
    test_reset_mid();
    test_full_depth();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
